// File: rtl/booth_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : booth_job_sequencer
// Description : Operand FIFO plus job sequencer in front of a Booth
//               multiplier. Issues one Q/M job at a time with a start pulse,
//               waits for done (with timeout), and presents the product on a
//               valid/ready output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_job_sequencer #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_q,
    input  logic [WIDTH-1:0]   in_m,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_q,
    output logic [WIDTH-1:0]   mul_m,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic               out_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(TIMEOUT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    // Last WAIT cycle in which a missing done turns into a timeout
    localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_start;
    logic [WIDTH-1:0] r_fifo_q [DEPTH];
    logic [WIDTH-1:0] r_fifo_m [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic [c_CW-1:0]  r_wait_cnt;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_done_ok;
    logic             w_timeout;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                       (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_push    = in_valid && !w_full;
    assign w_pop     = (r_state == c_IDLE) && !w_empty;
    // A done level left over from the previous job is still visible at
    // wait_cnt==0, so only a done seen from the second WAIT cycle is taken
    assign w_done_ok = (r_state == c_WAIT) && mul_done && (r_wait_cnt != '0);
    assign w_timeout = (r_state == c_WAIT) && !w_done_ok &&
                       (r_wait_cnt == c_WAIT_LAST);

    // State register; start pulse is registered alongside the ISSUE state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= (w_state_nxt == c_ISSUE);
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (!w_empty)               w_state_nxt = c_ISSUE;
            c_ISSUE:                             w_state_nxt = c_WAIT;
            c_WAIT:  if (w_done_ok || w_timeout) w_state_nxt = c_HOLD;
            c_HOLD:  if (out_ready)              w_state_nxt = c_IDLE;
            default:                             w_state_nxt = c_IDLE;
        endcase
    end

    // Combinational outputs
    always_comb begin
        in_ready  = !w_full;
        mul_start = r_start;
    end

    // FIFO storage; no reset needed, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_q[r_wptr[c_AW-1:0]] <= in_q;
            r_fifo_m[r_wptr[c_AW-1:0]] <= in_m;
        end
    end

    // FIFO pointers; a pop never frees a slot for a same-cycle push when full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Job datapath: operand capture, wait counter, result capture and hold
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_q      <= '0;
            mul_m      <= '0;
            r_wait_cnt <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
        end else begin
            if (w_pop) begin
                mul_q <= r_fifo_q[r_rptr[c_AW-1:0]];
                mul_m <= r_fifo_m[r_rptr[c_AW-1:0]];
            end
            case (r_state)
                c_ISSUE: r_wait_cnt <= '0;
                c_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (w_done_ok) begin
                        out_result <= mul_result;
                        out_err    <= 1'b0;
                        out_valid  <= 1'b1;
                    end else if (w_timeout) begin
                        out_result <= '0;
                        out_err    <= 1'b1;
                        out_valid  <= 1'b1;
                    end
                end
                c_HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_job_sequencer
// Description : Self-checking bench for booth_job_sequencer with a
//               behavioural multiplier and a queue-based job scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_job_sequencer;

    localparam int WIDTH      = 4;
    localparam int DEPTH      = 4;
    localparam int TIMEOUT    = 16;
    localparam int c_DONE_DLY = 6;

    typedef struct { logic [3:0] q; logic [3:0] m; } op_t;
    typedef struct { logic [7:0] res; logic err; int start_cyc; } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_q = '0;
    logic [3:0] in_m = '0;
    logic       mul_start;
    logic [3:0] mul_q;
    logic [3:0] mul_m;
    logic       mul_done = 1'b0;
    logic [7:0] mul_result = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result;
    logic       out_err;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    bit   nodone  = 1'b0;
    bit   busy    = 1'b0;
    int   mcnt    = 0;
    logic [3:0] model_q = '0;
    logic [3:0] model_m = '0;
    int   nstarts = 0;
    int   nacc    = 0;
    logic [7:0] last_res = '0;
    logic last_err = 1'b0;
    int   last_lat = 0;
    int   last_push_cyc = 0;
    int   last_start_cyc = 0;
    bit   active = 1'b0;
    bit   prev_valid = 1'b0;
    op_t  cur;
    op_t  o_tmp;
    exp_t e_tmp;
    op_t  op_q[$];
    exp_t res_q[$];

    booth_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_m(in_m),
        .mul_start(mul_start), .mul_q(mul_q), .mul_m(mul_m),
        .mul_done(mul_done), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // Two's complement product of two signed 4-bit operands, low 8 bits
    function automatic logic [7:0] ref_prod(input logic [3:0] q, input logic [3:0] m);
        int a;
        int b;
        a = $signed(q);
        b = $signed(m);
        return 8'(a * b);
    endfunction

    // Scoreboard and multiplier model, evaluated mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            op_q.delete();
            res_q.delete();
            active     = 1'b0;
            prev_valid = 1'b0;
            busy       = 1'b0;
            mul_done   = 1'b0;
        end else begin
            if (mul_start) begin
                chk("start_has_job", 32'(op_q.size() > 0), 1);
                chk("start_in_hold", 32'(out_valid), 0);
                if (op_q.size() > 0) begin
                    o_tmp = op_q.pop_front();
                    chk("issue_q", 32'(mul_q), 32'(o_tmp.q));
                    chk("issue_m", 32'(mul_m), 32'(o_tmp.m));
                    e_tmp.res       = nodone ? 8'h00 : ref_prod(o_tmp.q, o_tmp.m);
                    e_tmp.err       = nodone;
                    e_tmp.start_cyc = cyc;
                    res_q.push_back(e_tmp);
                    cur    = o_tmp;
                    active = 1'b1;
                end
                nstarts++;
                last_start_cyc = cyc;
            end else if (active) begin
                chk("stable_q", 32'(mul_q), 32'(cur.q));
                chk("stable_m", 32'(mul_m), 32'(cur.m));
            end

            chk("in_ready", 32'(in_ready), 32'(op_q.size() < DEPTH));

            if (out_valid) begin
                chk("valid_has_job", 32'(res_q.size() > 0), 1);
                if (res_q.size() > 0) begin
                    if (!prev_valid) begin
                        last_lat = cyc - res_q[0].start_cyc;
                        chk("latency", 32'(last_lat),
                            res_q[0].err ? 32'(TIMEOUT + 1) : 32'(c_DONE_DLY + 1));
                        active = 1'b0;
                    end
                    chk("result", 32'(out_result), 32'(res_q[0].res));
                    chk("err", 32'(out_err), 32'(res_q[0].err));
                    if (out_ready) begin
                        last_res = out_result;
                        last_err = out_err;
                        nacc++;
                        void'(res_q.pop_front());
                    end
                end
            end
            prev_valid = out_valid;

            if (in_valid && in_ready) begin
                o_tmp.q = in_q;
                o_tmp.m = in_m;
                op_q.push_back(o_tmp);
                last_push_cyc = cyc;
            end

            // Multiplier: done drops shortly after a start, rises 6 cycles
            // after it and then stays high until the next start
            if (mul_start) begin
                busy    = 1'b1;
                mcnt    = 0;
                model_q = mul_q;
                model_m = mul_m;
            end else if (busy) begin
                mcnt++;
                if (mcnt == 2) mul_done = 1'b0;
                if (mcnt == c_DONE_DLY) begin
                    busy = 1'b0;
                    if (!nodone) begin
                        mul_done   = 1'b1;
                        mul_result = ref_prod(model_q, model_m);
                    end
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] q, input logic [3:0] m);
        int b;
        b = 0;
        in_valid = 1'b1;
        in_q = q;
        in_m = m;
        while (!in_ready && b < 100) begin
            step();
            b++;
        end
        chk("push_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int b;
        b = 0;
        while (!out_valid && b < budget) begin
            step();
            b++;
        end
        chk("wait_valid", 32'(out_valid), 1);
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = 0;
        while ((op_q.size() != 0 || res_q.size() != 0) && b < budget) begin
            step();
            b++;
        end
        chk("drain", 32'(op_q.size() + res_q.size()), 0);
        step();
        step();
    endtask

    initial begin
        int s0;
        int a0;
        int b;

        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_mul_start", 32'(mul_start), 0);
        chk("rst_mul_q", 32'(mul_q), 0);
        chk("rst_mul_m", 32'(mul_m), 0);
        chk("rst_out_result", 32'(out_result), 0);
        chk("rst_out_err", 32'(out_err), 0);
        rst = 1'b0;
        step();

        // Single job: 3 x -6
        out_ready = 1'b1;
        s0 = nstarts;
        push(4'b0011, 4'b1010);
        wait_drain(100);
        chk("t1_starts", 32'(nstarts - s0), 1);
        chk("t1_issue_lat", 32'(last_start_cyc - last_push_cyc), 2);
        chk("t1_res", 32'(last_res), 32'h0000_00EE);
        chk("t1_err", 32'(last_err), 0);

        // Back-pressure: six back-to-back offers with the output stalled
        out_ready = 1'b0;
        a0 = nacc;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_q = 4'(i + 1);
            in_m = 4'(15 - i);
            if (i == 5) chk("t2_full", 32'(in_ready), 0);
            step();
        end
        in_valid = 1'b0;
        repeat (12) step();
        chk("t2_held_valid", 32'(out_valid), 1);
        chk("t2_still_full", 32'(in_ready), 0);
        out_ready = 1'b1;
        wait_drain(300);
        chk("t2_count", 32'(nacc - a0), 5);

        // Result held stable while downstream stalls
        out_ready = 1'b0;
        push(4'd3, 4'd3);
        wait_valid(50);
        push(4'd1, 4'd1);
        for (int k = 0; k < 10; k++) begin
            chk("t3_valid", 32'(out_valid), 1);
            chk("t3_res", 32'(out_result), 32'h09);
            chk("t3_nostart", 32'(mul_start), 0);
            step();
        end
        out_ready = 1'b1;
        wait_drain(100);

        // Timeout, then a normal job
        out_ready = 1'b0;
        nodone = 1'b1;
        push(4'd2, 4'd2);
        wait_valid(60);
        step();
        chk("t4_err", 32'(out_err), 1);
        chk("t4_res", 32'(out_result), 0);
        chk("t4_lat", 32'(last_lat), 32'(TIMEOUT + 1));
        nodone = 1'b0;
        push(4'd2, 4'd3);
        out_ready = 1'b1;
        wait_drain(100);
        chk("t4_next_res", 32'(last_res), 32'h06);
        chk("t4_next_err", 32'(last_err), 0);

        // Stale done from the previous job during the new ISSUE
        push(4'd1, 4'd1);
        push(4'b1000, 4'b0111);
        wait_drain(100);
        chk("t5_res", 32'(last_res), 32'h0000_00C8);

        // Reset in WAIT with two jobs queued
        push(4'd2, 4'd5);
        b = 0;
        while (!mul_start && b < 20) begin
            step();
            b++;
        end
        chk("t6_start", 32'(mul_start), 1);
        step();
        push(4'd1, 4'd2);
        push(4'd3, 4'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_ready", 32'(in_ready), 1);
        chk("t6_start0", 32'(mul_start), 0);
        a0 = nacc;
        s0 = nstarts;
        repeat (20) step();
        chk("t6_no_results", 32'(nacc - a0), 0);
        chk("t6_no_starts", 32'(nstarts - s0), 0);
        push(4'd5, 4'b1101);
        wait_drain(100);
        chk("t6_res", 32'(last_res), 32'h0000_00F1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_q      = 4'($urandom);
            in_m      = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain(600);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
